// File: rtl/alu_ctrl_pkg.sv
// Shared types and encodings for the EX-stage ALU decoder and RV32M sequencer.
package alu_ctrl_pkg;

  // ALU operation codes driven to the EX-stage ALU.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_BAD  = 4'b1010
  } alu_ctrl_e;

  // Main-decoder ALU operation class.
  typedef enum logic [1:0] {
    AOP_MEM   = 2'b00,
    AOP_BR    = 2'b01,
    AOP_ARITH = 2'b10,
    AOP_RSVD  = 2'b11
  } aluop_e;

  // Multiply/divide sequencer states.
  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/mdu_iter_core.sv
// Radix-2 iterative datapath: shift-add multiply and restoring divide on
// unsigned magnitudes. One step per cycle; XLEN steps per operation.
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,     // capture operands, clear acc and cnt
  input  logic            step,     // perform one iteration
  input  logic            is_div,   // 1: restoring divide, 0: shift-add multiply
  input  logic [XLEN-1:0] a_in,     // multiplier / dividend magnitude
  input  logic [XLEN-1:0] b_in,     // multiplicand / divisor magnitude
  output logic [XLEN-1:0] acc,      // product high half / remainder
  output logic [XLEN-1:0] quo,      // product low half / quotient
  output logic            last      // current step is the final one
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] rem_diff;

  // Next-state computation for one multiply or divide iteration.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    acc_d    = acc_q;
    quo_d    = quo_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    mul_sum  = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {acc_q, quo_q[XLEN-1]};
    rem_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
    if (load) begin
      acc_d  = '0;
      quo_d  = a_in;
      opnd_d = b_in;
      cnt_d  = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div) begin
        // Restore (keep the shifted remainder) when the trial subtract borrows.
        if (rem_diff[XLEN+1]) begin
          acc_d = rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end else begin
          acc_d = rem_diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end
      end else begin
        // {acc,quo} shifts right as a 2*XLEN product register.
        acc_d = mul_sum[XLEN:1];
        quo_d = {mul_sum[0], quo_q[XLEN-1:1]};
      end
    end
  end

  // Datapath registers.
  // NOTE: datapath registers are reset too, so results never expose X after power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      quo_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      acc_q  <= acc_d;
      quo_q  <= quo_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign acc  = acc_q;
  assign quo  = quo_q;
  assign last = (cnt_q == CW'(XLEN - 1));

endmodule

// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU decoder with an RV32M iterative multiply/divide sequencer.
// Decode is combinational; the sequencer stalls IF/ID/EX until its result is ready.
module alu_ctrl_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit EN_M   = 1'b1,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        aluop,
  input  logic [6:0]        funct7,
  input  logic [2:0]        funct3,
  input  logic              is_imm,
  input  logic              op_valid,
  input  logic              flush,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic              is_md,
  output logic              md_stall,
  output logic              md_valid,
  output logic [XLEN-1:0]   md_result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [3:0] ctrl;

  // ALU decode: R-type and I-type are separated so immediate bits never select SUB.
  always_comb begin
    ctrl    = ALU_ADD;
    illegal = 1'b0;
    is_md   = 1'b0;
    case (aluop_e'(aluop))
      AOP_MEM: ctrl = ALU_ADD;
      AOP_BR: begin
        case (funct3)
          3'b000, 3'b001: ctrl = ALU_SUB;
          3'b100, 3'b101: ctrl = ALU_SLT;
          3'b110, 3'b111: ctrl = ALU_SLTU;
          default: begin
            ctrl    = ALU_BAD;
            illegal = 1'b1;
          end
        endcase
      end
      AOP_ARITH: begin
        if (is_imm) begin
          ctrl    = {(funct3 == 3'b101) & funct7[5], funct3};
          illegal = ((funct3 == 3'b001) && (funct7 != F7_BASE)) ||
                    ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
        end else if ((funct7 == F7_BASE) || (funct7 == F7_ALT)) begin
          ctrl = {funct7[5], funct3};
        end else if ((funct7 == F7_MULDIV) && EN_M) begin
          is_md = 1'b1;
          ctrl  = ALU_ADD;
        end else begin
          ctrl    = ALU_BAD;
          illegal = 1'b1;
        end
      end
      default: begin
        ctrl    = ALU_BAD;
        illegal = 1'b1;
      end
    endcase
  end

  assign alu_ctrl = CTRL_W'(ctrl);

  // Operand conditioning at accept: signedness, magnitudes and special cases.
  logic            s1_signed, s2_signed, a_neg, b_neg, res_neg;
  logic            div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  assign s1_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
  assign s2_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg     = s1_signed & rs1_val[XLEN-1];
  assign b_neg     = s2_signed & rs2_val[XLEN-1];
  assign a_mag     = a_neg ? -rs1_val : rs1_val;
  assign b_mag     = b_neg ? -rs2_val : rs2_val;
  // Remainder takes the dividend's sign; everything else takes s1^s2.
  assign res_neg   = (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);
  assign div0      = funct3[2] & (rs2_val == '0);
  assign ovf       = funct3[2] & ~funct3[0] & (rs1_val == INT_MIN) & (rs2_val == '1);
  assign spec_res  = div0 ? (funct3[1] ? rs1_val : '1)
                          : (funct3[1] ? '0 : rs1_val);

  md_state_e       state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] spec_res_q, spec_res_d;
  logic [XLEN-1:0] md_result_q, md_result_d;

  logic            start, core_load, core_step, core_last;
  logic [XLEN-1:0] core_acc, core_quo;

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (core_load),
    .step   (core_step),
    .is_div (f3_q[2]),
    .a_in   (a_mag),
    .b_in   (b_mag),
    .acc    (core_acc),
    .quo    (core_quo),
    .last   (core_last)
  );

  // Final result selection and sign fix-up, valid while in DONE.
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   q_s, r_s, final_res;

  assign prod      = {core_acc, core_quo};
  assign prod_s    = neg_q ? -prod : prod;
  assign q_s       = neg_q ? -core_quo : core_quo;
  assign r_s       = neg_q ? -core_acc : core_acc;
  assign final_res = special_q ? spec_res_q :
                     f3_q[2]   ? (f3_q[1] ? r_s : q_s) :
                     (f3_q == 3'b000) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

  assign start = is_md & op_valid & ~flush;

  // Sequencer next-state: IDLE -> RUN -> DONE -> IDLE, with special cases skipping RUN.
  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    neg_d       = neg_q;
    special_d   = special_q;
    spec_res_d  = spec_res_q;
    md_result_d = md_result_q;
    core_load   = 1'b0;
    core_step   = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          f3_d       = funct3;
          neg_d      = res_neg;
          special_d  = div0 | ovf;
          spec_res_d = spec_res;
          if (div0 | ovf) begin
            state_d = MD_DONE;
          end else begin
            state_d   = MD_RUN;
            core_load = 1'b1;
          end
        end
      end
      MD_RUN: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          core_step = 1'b1;
          if (core_last) state_d = MD_DONE;
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
        if (!flush) md_result_d = final_res;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Sequencer state and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MD_IDLE;
      f3_q        <= '0;
      neg_q       <= 1'b0;
      special_q   <= 1'b0;
      spec_res_q  <= '0;
      md_result_q <= '0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      neg_q       <= neg_d;
      special_q   <= special_d;
      spec_res_q  <= spec_res_d;
      md_result_q <= md_result_d;
    end
  end

  // The result is presented directly in DONE so it lines up with md_valid.
  assign md_result = (state_q == MD_DONE) ? final_res : md_result_q;
  assign md_valid  = (state_q == MD_DONE) & ~flush;
  assign md_stall  = is_md & op_valid & ~flush & (state_q != MD_DONE);

endmodule
